// File: rtl/alu_muldiv_unit.sv
// -----------------------------------------------------------------------------
// alu_muldiv_unit
//   XLEN-wide execute unit with valid/ready handshakes on both sides.
//   Single-cycle ops: ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA.
//   Iterative ops (XLEN cycles): MUL (low half), DIVU, REMU.
//
// Ports
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous active-low reset
//   in_valid   in   1     op/src_a/src_b valid
//   in_ready   out  1     unit can accept an operation this cycle
//   op         in   4     operation select
//   src_a      in   XLEN  operand 1
//   src_b      in   XLEN  operand 2
//   out_valid  out  1     result valid, held until accepted
//   out_ready  in   1     consumer accepts result
//   result     out  XLEN  registered result
//   zero       out  1     result == 0
//   sign       out  1     result[XLEN-1]
//   busy       out  1     multi-cycle operation in progress
// -----------------------------------------------------------------------------
module alu_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            sign,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN) + 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_SLTU = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] result_q;
  logic            out_valid_q;

  // Iteration registers.
  //   MUL: opa = multiplicand (shifts left), opb = multiplier (shifts right),
  //        acc = running product.
  //   DIV: opa = dividend shifting out / quotient shifting in, opb = divisor,
  //        acc = partial remainder.
  logic [XLEN-1:0] opa, opb, acc;
  logic            want_rem;

  logic            accept, is_mul, is_div, last_step;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] mul_acc_nxt;
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_rem_nxt, div_quo_nxt;

  assign is_mul    = (op == OP_MUL);
  assign is_div    = (op == OP_DIVU) || (op == OP_REMU);
  assign accept    = in_valid && in_ready;
  assign last_step = (cnt == CW'(1));
  assign shamt     = src_b[SHW-1:0];

  // ---------------------------------------------------------------------------
  // Single-cycle ALU
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      OP_SLL:  alu_res = src_a << shamt;
      OP_SRL:  alu_res = src_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One iteration step of shift-add multiply / restoring divide
  // ---------------------------------------------------------------------------
  always_comb begin
    mul_acc_nxt = acc + (opb[0] ? opa : '0);
    // The partial remainder stays below the divisor, so one extra bit holds the
    // shifted value; the subtraction result always fits back into XLEN bits.
    // A zero divisor makes every step "fit": quotient all ones, remainder = a.
    div_shift   = {acc, opa[XLEN-1]};
    div_ge      = (div_shift >= {1'b0, opb});
    div_rem_nxt = div_ge ? (div_shift[XLEN-1:0] - opb) : div_shift[XLEN-1:0];
    div_quo_nxt = {opa[XLEN-2:0], div_ge};
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept && is_mul)      state_nxt = ST_MUL;
        else if (accept && is_div) state_nxt = ST_DIV;
      end
      ST_MUL, ST_DIV: begin
        if (last_step) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != ST_IDLE);
    in_ready = (state == ST_IDLE) && (!out_valid_q || out_ready);
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand/iteration registers are reset too, so an aborted operation
      // leaves nothing behind that could leak into a later result.
      cnt         <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      opa         <= '0;
      opb         <= '0;
      acc         <= '0;
      want_rem    <= 1'b0;
    end else if (accept) begin
      if (is_mul || is_div) begin
        cnt         <= CW'(XLEN);
        out_valid_q <= 1'b0;
        opa         <= src_a;
        opb         <= src_b;
        acc         <= '0;
        want_rem    <= (op == OP_REMU);
      end else begin
        result_q    <= alu_res;
        out_valid_q <= 1'b1;
      end
    end else if (state != ST_IDLE) begin
      cnt <= cnt - CW'(1);
      if (state == ST_MUL) begin
        acc <= mul_acc_nxt;
        opa <= opa << 1;
        opb <= opb >> 1;
      end else begin
        acc <= div_rem_nxt;
        opa <= div_quo_nxt;
      end
      if (last_step) begin
        out_valid_q <= 1'b1;
        if (state == ST_MUL)  result_q <= mul_acc_nxt;
        else if (want_rem)    result_q <= div_rem_nxt;
        else                  result_q <= div_quo_nxt;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign zero      = (result_q == '0);
  assign sign      = result_q[XLEN-1];

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_muldiv_unit
//   Self-checking bench for alu_muldiv_unit (XLEN = 32). A behavioural model
//   tracks what the outputs must be from the operation semantics and latency;
//   a compare process checks the DUT against it every cycle, and directed
//   vectors check hand-computed literal results.
// -----------------------------------------------------------------------------
module tb_alu_muldiv_unit;

  localparam int XLEN = 32;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_SLTU = 4'b1111;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [3:0]      op = 4'b0;
  logic [XLEN-1:0] src_a = '0;
  logic [XLEN-1:0] src_b = '0;
  logic            in_ready, out_valid, zero, sign, busy;
  logic [XLEN-1:0] result;

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  alu_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .sign      (sign),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] model_op(input logic [3:0] o,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    int unsigned sh;
    logic [XLEN-1:0] r;
    sh = b % XLEN;
    case (o)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = ($signed(a) < $signed(b)) ? 1 : 0;
      OP_SLTU: r = (a < b) ? 1 : 0;
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $signed(a) >>> sh;
      OP_MUL:  r = a * b;
      OP_DIVU: r = (b == 0) ? '1 : a / b;
      OP_REMU: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic bit is_multi(input logic [3:0] o);
    return (o == OP_MUL) || (o == OP_DIVU) || (o == OP_REMU);
  endfunction

  int              m_remain = 0;    // cycles until a pending long op delivers
  logic            m_ov = 1'b0;
  logic [XLEN-1:0] m_res = '0;
  logic [XLEN-1:0] m_pend = '0;
  bit              m_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_remain = 0;
      m_ov     = 1'b0;
      m_res    = '0;
    end else begin
      m_rdy = (m_remain == 0) && (!m_ov || out_ready);
      if (m_remain > 0) begin
        m_remain--;
        if (m_remain == 0) begin
          m_ov  = 1'b1;
          m_res = m_pend;
        end
      end else begin
        if (m_ov && out_ready) m_ov = 1'b0;
        if (in_valid && m_rdy) begin
          if (is_multi(op)) begin
            m_remain = XLEN;
            m_pend   = model_op(op, src_a, src_b);
            m_ov     = 1'b0;
          end else begin
            m_res = model_op(op, src_a, src_b);
            m_ov  = 1'b1;
          end
        end
      end
    end
  end

  // Compare process: outputs are sampled 1 time unit after the falling edge.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && cmp_en) begin
      check("cmp_out_valid", out_valid, m_ov);
      check("cmp_busy", busy, m_remain > 0);
      check("cmp_in_ready", in_ready, (m_remain == 0) && (!m_ov || out_ready));
      check("cmp_result", result, m_res);
      check("cmp_zero", zero, m_res == 0);
      check("cmp_sign", sign, m_res[XLEN-1]);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic run_op(input string name, input logic [3:0] o,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp, input int exp_lat);
    int n;
    int waitc;
    @(negedge clk);
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    #1;
    waitc = 0;
    while (!in_ready && waitc < 100) begin
      @(negedge clk); #1; waitc++;
    end
    check({name, "_accept"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    // Scramble operands after accept; long ops also keep a bogus request up.
    src_a = ~a; src_b = b + 1; op = OP_ADD;
    in_valid = (exp_lat > 0);
    #1;
    n = 0;
    while (!out_valid && n < 200) begin
      check({name, "_busy"}, busy, 1);
      check({name, "_in_ready_low"}, in_ready, 0);
      @(negedge clk); #1; n++;
    end
    in_valid = 1'b0;
    check({name, "_latency"}, n, exp_lat);
    check({name, "_result"}, result, exp);
    check({name, "_zero"}, zero, exp == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_sign", sign, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    cmp_en = 1'b1;

    // Single-cycle operations
    run_op("add_wrap", OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0);
    run_op("sub_neg",  OP_SUB,  32'd5,         32'd7,         32'hFFFF_FFFE, 0);
    run_op("slt",      OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0);
    run_op("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0);
    run_op("sra",      OP_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000, 0);
    run_op("srl",      OP_SRL,  32'h8000_0000, 32'd31,        32'h0000_0001, 0);
    run_op("sll",      OP_SLL,  32'h0000_0001, 32'd31,        32'h8000_0000, 0);
    run_op("sll_mask", OP_SLL,  32'h0000_0001, 32'd33,        32'h0000_0002, 0);
    run_op("and",      OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 0);
    run_op("or",       OP_OR,   32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 0);
    run_op("xor",      OP_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 0);
    run_op("bad_op",   4'b1001, 32'h1234_5678, 32'h1,         32'h0000_0000, 0);

    // Iterative operations
    run_op("mul",      OP_MUL,  32'h0001_0001, 32'h0001_0001, 32'h0002_0001, XLEN);
    run_op("mul_wrap", OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, XLEN);
    run_op("divu",     OP_DIVU, 32'd100,       32'd7,         32'd14,        XLEN);
    run_op("remu",     OP_REMU, 32'd100,       32'd7,         32'd2,         XLEN);
    run_op("divu_z",   OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, XLEN);
    run_op("remu_z",   OP_REMU, 32'd5,         32'd0,         32'd5,         XLEN);
    run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, XLEN);

    // Back-to-back single-cycle ops: one result per cycle
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      op = OP_ADD; src_a = i; src_b = i * 16; in_valid = 1'b1;
      #1;
      if (i > 1) begin
        check("b2b_valid", out_valid, 1);
        check("b2b_result", result, (i - 1) * 17);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("b2b_last", result, 68);

    // Backpressure: ADD 3+4 held, then XOR 6^3 accepted on release
    @(negedge clk);
    op = OP_ADD; src_a = 32'd3; src_b = 32'd4; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    op = OP_XOR; src_a = 32'd6; src_b = 32'd3;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_valid", out_valid, 1);
      check("bp_result", result, 7);
      check("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("bp_next_valid", out_valid, 1);
    check("bp_next_result", result, 5);

    // Reset in the middle of a DIVU
    @(negedge clk);
    op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_result", result, 0);
    check("abort_zero", zero, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("divu_after_rst", OP_DIVU, 32'd100, 32'd7, 32'd14, XLEN);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
